gtxe2_chnl_tx_oob: RTL and testbench
====================================

# gtxe2_chnl_tx_oob

Out-of-band (OOB) signalling sequencer for the GTXE2 channel TX path. It sits in the TXUSRCLK domain directly in front of the TX serializer and owns the serializer's parallel data and idle-flag inputs. On a COMINIT, COMWAKE or COMSAS request it emits a fixed train of data bursts separated by electrical-idle gaps, then reports completion. Otherwise it passes user data and the electrical-idle request straight through.

## Interface
Parameters:
- width, 20, parallel word width; must equal the serializer width
- burst_pattern, 20'b10101010101010101010, word driven during every burst word; low `width` bits used
- burst_len, 16, words per burst (1..65535)
- burst_count, 6, bursts per sequence (1..255)
- init_gap, 48, idle words after each burst in COMINIT (1..65535)
- wake_gap, 16, idle words after each burst in COMWAKE (1..65535)
- sas_gap, 144, idle words after each burst in COMSAS (1..65535)

Ports:
- clk  in  1  TXUSRCLK; all logic on rising edge
- reset  in  1  synchronous, active-high
- txcominit  in  1  COMINIT request, sampled every cycle
- txcomwake  in  1  COMWAKE request
- txcomsas  in  1  COMSAS request
- txelecidle  in  1  user electrical-idle request
- indata  in  width  user TX word
- outdata  out  width  word to serializer
- idle_out  out  1  idle-line flag to serializer (1 = TXP/TXN both 0)
- txcomfinish  out  1  one-cycle pulse at sequence end
- busy  out  1  OOB sequence in progress

## Operation
- FSM states: IDLE, BURST, GAP. All outputs registered.
- IDLE: outdata <= indata; idle_out <= txelecidle; busy <= 0.
- Request accepted only in IDLE and only when txelecidle=1 in the same cycle. Requests in BURST/GAP, or with txelecidle=0, are dropped, not queued, and produce no txcomfinish.
- Simultaneous requests: priority COMINIT > COMWAKE > COMSAS. The gap length is latched at acceptance into a 16-bit gap register.
- Accept -> BURST, word counter = 0, burst counter = 0.
- BURST: outdata <= burst_pattern; idle_out <= 0; busy <= 1. After burst_len words -> GAP, word counter cleared.
- GAP: outdata <= 0; idle_out <= 1; busy <= 1. After the latched gap words:
  - if burst counter = burst_count-1 -> IDLE;
  - else burst counter +1 and -> BURST.
- Every burst, including the last, is followed by a full gap.
- txcomfinish = 1 while the last gap word of the last burst is presented; 0 otherwise.
- Counters: word counter 16 bit, burst counter 8 bit. Terminal compare is equality to (parameter-1), with no wrap past it.
- txelecidle and indata are ignored while busy=1.
- Reset at any time, including mid-sequence: next cycle state=IDLE, counters 0, outdata=0, idle_out=1, txcomfinish=0, busy=0. The sequence is aborted with no finish pulse.

## Timing
- Reset values: outdata=0, idle_out=1, txcomfinish=0, busy=0.
- Passthrough latency: 1 cycle from indata/txelecidle to outdata/idle_out.
- Request sampled at edge of cycle N. Definitions:
  - T = burst_count*(burst_len+gap)
  - P = burst_len+gap
- Outputs during the sequence:
  - first burst word on outdata in cycle N+1;
  - burst k (k=0..burst_count-1) occupies N+1+k·P .. N+k·P+burst_len;
  - its gap occupies the following gap cycles.
- busy=1 in cycles N+1..N+T; txcomfinish=1 in cycle N+T only.
- Cycle N+T+1: passthrough of inputs sampled at N+T. The earliest next acceptance is a request sampled at N+T+1; a request sampled at N+T is dropped.

## Test plan
- Reset, then idle: outdata=0, idle_out=1, busy=0. Then indata=20'h5A5A5, txelecidle=0 -> one cycle later outdata=20'h5A5A5, idle_out=0.
- Defaults, txelecidle=1, one-cycle txcominit at N -> 6 bursts of 16 pattern words, each followed by 48 idle words. busy over N+1..N+384; single txcomfinish at N+384.
- txcomwake with defaults -> gaps of 16 words, T=192, finish at N+192. txcomsas -> gaps of 144 words, T=960.
- txcominit and txcomwake in the same cycle -> COMINIT timing (T=384). txcomwake pulsed at N+50 during the sequence -> ignored, one finish only.
- txcominit with txelecidle=0 -> no sequence, busy stays 0, no finish, passthrough continues.
- reset asserted at N+100 of a COMINIT -> at N+101 outdata=0, idle_out=1, busy=0, no txcomfinish. A new txcomwake then runs a full 192-cycle sequence.

Source files
------------

// File: rtl/gtxe2_chnl_tx_oob.sv
// gtxe2_chnl_tx_oob
// Out-of-band signalling sequencer in front of the GTXE2 TX serializer.
// On a COMINIT/COMWAKE/COMSAS request, accepted only while idle and while
// txelecidle is high, it drives burst_count bursts of burst_len pattern
// words. Each burst is followed by a full idle gap whose length depends on
// the request type. txcomfinish pulses on the last gap word. Outside a
// sequence, indata and txelecidle pass through with one cycle of latency.
//
// Ports:
//   clk         TXUSRCLK; all logic on the rising edge
//   reset       synchronous, active-high
//   txcominit   COMINIT request (highest priority)
//   txcomwake   COMWAKE request
//   txcomsas    COMSAS request (lowest priority)
//   txelecidle  user electrical-idle request; also gates request acceptance
//   indata      user TX word
//   outdata     registered word to the serializer
//   idle_out    registered idle-line flag to the serializer
//   txcomfinish one-cycle pulse on the final gap word of a sequence
//   busy        high while an OOB sequence is being driven
module gtxe2_chnl_tx_oob #(
  parameter int width         = 20,
  parameter     burst_pattern = 20'b10101010101010101010,
  parameter int burst_len     = 16,
  parameter int burst_count   = 6,
  parameter int init_gap      = 48,
  parameter int wake_gap      = 16,
  parameter int sas_gap       = 144
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             txcominit,
  input  logic             txcomwake,
  input  logic             txcomsas,
  input  logic             txelecidle,
  input  logic [width-1:0] indata,
  output logic [width-1:0] outdata,
  output logic             idle_out,
  output logic             txcomfinish,
  output logic             busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] BURST = 2'd1;
  localparam logic [1:0] GAP   = 2'd2;

  localparam logic [width-1:0] PATTERN  = width'(burst_pattern);
  localparam logic [15:0]      BLEN_M1  = 16'(burst_len - 1);
  localparam logic [7:0]       BCNT_M1  = 8'(burst_count - 1);
  localparam logic [15:0]      INIT_GAP = 16'(init_gap);
  localparam logic [15:0]      WAKE_GAP = 16'(wake_gap);
  localparam logic [15:0]      SAS_GAP  = 16'(sas_gap);

  logic [1:0]       state_q, state_d;
  logic [15:0]      word_q, word_d;
  logic [7:0]       burst_q, burst_d;
  logic [15:0]      gap_q, gap_d;
  logic [width-1:0] outdata_q, outdata_d;
  logic             idle_q, idle_d;
  logic             finish_q, finish_d;
  logic             busy_q, busy_d;

  // word_q is the index of the word currently on outdata within the
  // current burst or gap, so terminal compares look at what is presented now.
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    burst_d = burst_q;
    gap_d   = gap_q;
    case (state_q)
      IDLE: begin
        if (txelecidle && (txcominit || txcomwake || txcomsas)) begin
          state_d = BURST;
          word_d  = 16'd0;
          burst_d = 8'd0;
          if (txcominit)      gap_d = INIT_GAP;
          else if (txcomwake) gap_d = WAKE_GAP;
          else                gap_d = SAS_GAP;
        end
      end
      BURST: begin
        if (word_q == BLEN_M1) begin
          state_d = GAP;
          word_d  = 16'd0;
        end else begin
          word_d = word_q + 16'd1;
        end
      end
      GAP: begin
        if (word_q == gap_q - 16'd1) begin
          word_d = 16'd0;
          if (burst_q == BCNT_M1) begin
            state_d = IDLE;
            burst_d = 8'd0;
          end else begin
            state_d = BURST;
            burst_d = burst_q + 8'd1;
          end
        end else begin
          word_d = word_q + 16'd1;
        end
      end
      default: begin
        state_d = IDLE;
        word_d  = 16'd0;
        burst_d = 8'd0;
      end
    endcase
  end

  // Outputs are decoded from the next state so that the first burst word
  // appears the cycle after acceptance and passthrough resumes the cycle
  // after the final gap word.
  always_comb begin
    outdata_d = indata;
    idle_d    = txelecidle;
    busy_d    = 1'b0;
    case (state_d)
      BURST: begin
        outdata_d = PATTERN;
        idle_d    = 1'b0;
        busy_d    = 1'b1;
      end
      GAP: begin
        outdata_d = '0;
        idle_d    = 1'b1;
        busy_d    = 1'b1;
      end
      default: ;
    endcase
    // Evaluated on the next word so that a single-word gap also flags finish.
    finish_d = (state_d == GAP) && (word_d == gap_d - 16'd1) &&
               (burst_d == BCNT_M1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      word_q    <= 16'd0;
      burst_q   <= 8'd0;
      gap_q     <= 16'd0;
      outdata_q <= '0;
      idle_q    <= 1'b1;
      finish_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      word_q    <= word_d;
      burst_q   <= burst_d;
      gap_q     <= gap_d;
      outdata_q <= outdata_d;
      idle_q    <= idle_d;
      finish_q  <= finish_d;
      busy_q    <= busy_d;
    end
  end

  assign outdata     = outdata_q;
  assign idle_out    = idle_q;
  assign txcomfinish = finish_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_gtxe2_chnl_tx_oob.sv
module tb_gtxe2_chnl_tx_oob;

  localparam logic [19:0] PAT = 20'b10101010101010101010;

  logic        clk = 1'b0;
  logic        reset;
  logic        txcominit, txcomwake, txcomsas, txelecidle;
  logic [19:0] indata;
  logic [19:0] outdata;
  logic        idle_out, txcomfinish, busy;

  int n_checks = 0;
  int n_fail   = 0;

  gtxe2_chnl_tx_oob dut (
    .clk         (clk),
    .reset       (reset),
    .txcominit   (txcominit),
    .txcomwake   (txcomwake),
    .txcomsas    (txcomsas),
    .txelecidle  (txelecidle),
    .indata      (indata),
    .outdata     (outdata),
    .idle_out    (idle_out),
    .txcomfinish (txcomfinish),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Expected {outdata, idle_out, busy, txcomfinish} in cycle N+k of a
  // sequence with default burst_len=16 and the given gap and total length.
  function automatic logic [22:0] exp_at(input int k, input int gap, input int t);
    int idx;
    logic b;
    idx = (k - 1) % (16 + gap);
    b   = (idx < 16);
    return {(b ? PAT : 20'h0), ~b, 1'b1, (k == t)};
  endfunction

  // Holds the given request for exactly one sampling edge. On return the
  // bench is in cycle N+1, where N is the edge that sampled the request.
  task automatic drive_req(input logic i, input logic w, input logic s);
    @(posedge clk); #1;
    txcominit = i; txcomwake = w; txcomsas = s;
    @(posedge clk); #1;
    txcominit = 0; txcomwake = 0; txcomsas = 0;
  endtask

  task automatic test_reset;
    reset = 1; txelecidle = 0; indata = 20'hFFFFF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (outdata !== 20'h0) begin n_fail++; $display("FAIL reset_outdata got %h expected 00000", outdata); end
    n_checks++;
    if (idle_out !== 1'b1) begin n_fail++; $display("FAIL reset_idle got %b expected 1", idle_out); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b expected 0", busy); end
    n_checks++;
    if (txcomfinish !== 1'b0) begin n_fail++; $display("FAIL reset_finish got %b expected 0", txcomfinish); end
  endtask

  task automatic test_passthrough;
    @(posedge clk); #1;
    reset = 0; indata = 20'h5A5A5; txelecidle = 0;
    @(posedge clk); @(negedge clk);
    n_checks++;
    if ({outdata, idle_out, busy} !== {20'h5A5A5, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL pass_5a5a5 got %h/%b/%b expected 5a5a5/0/0", outdata, idle_out, busy);
    end
    @(posedge clk); #1;
    indata = 20'h0F0F0; txelecidle = 1;
    @(posedge clk); @(negedge clk);
    n_checks++;
    if ({outdata, idle_out, busy} !== {20'h0F0F0, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL pass_0f0f0 got %h/%b/%b expected 0f0f0/1/0", outdata, idle_out, busy);
    end
  endtask

  // One full sequence with inputs changed mid-way to show they are ignored.
  task automatic test_sequence(input string name, input logic i, input logic w,
                               input logic s, input int gap);
    int t;
    int fin;
    logic [22:0] got, exp;
    t = 6 * (16 + gap);
    fin = 0;
    txelecidle = 1; indata = 20'h12345;
    drive_req(i, w, s);
    for (int k = 1; k <= t; k++) begin
      @(negedge clk);
      got = {outdata, idle_out, busy, txcomfinish};
      exp = exp_at(k, gap, t);
      if (txcomfinish === 1'b1) fin++;
      n_checks++;
      if (got !== exp) begin
        n_fail++; $display("FAIL %s cyc %0d got %h expected %h", name, k, got, exp);
      end
      if (k == 50) begin txcomwake = 1; txelecidle = 0; indata = 20'h77777; end
      if (k == 51) begin txcomwake = 0; txelecidle = 1; indata = 20'h12345; end
    end
    @(negedge clk);
    got = {outdata, idle_out, busy, txcomfinish};
    n_checks++;
    if (got !== {20'h12345, 1'b1, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL %s_after got %h expected %h", name, got, {20'h12345, 3'b100});
    end
    n_checks++;
    if (fin !== 1) begin n_fail++; $display("FAIL %s_finish_count got %0d expected 1", name, fin); end
  endtask

  task automatic test_no_elecidle;
    logic [22:0] got;
    txelecidle = 0; indata = 20'hABCDE;
    drive_req(1, 0, 0);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      got = {outdata, idle_out, busy, txcomfinish};
      n_checks++;
      if (got !== {20'hABCDE, 3'b000}) begin
        n_fail++; $display("FAIL no_elecidle cyc %0d got %h expected %h", k, got, {20'hABCDE, 3'b000});
      end
    end
    txelecidle = 1;
  endtask

  // Request present at N+T is dropped; request at N+T+1 starts a new run.
  task automatic test_back_to_back;
    logic [22:0] got, exp;
    txelecidle = 1; indata = 20'h2468A;
    drive_req(0, 1, 0);
    for (int k = 1; k <= 192; k++) begin
      @(negedge clk);
      if (k == 192) begin
        n_checks++;
        if (txcomfinish !== 1'b1) begin n_fail++; $display("FAIL b2b_finish got %b expected 1", txcomfinish); end
        txcomwake = 1;
      end
    end
    @(negedge clk);
    got = {outdata, idle_out, busy, txcomfinish};
    n_checks++;
    if (got !== {20'h2468A, 3'b100}) begin
      n_fail++; $display("FAIL b2b_dropped got %h expected %h", got, {20'h2468A, 3'b100});
    end
    @(posedge clk); #1;
    txcomwake = 0;
    // Now in cycle N'+1 of the second request, sampled one edge earlier.
    for (int k = 1; k <= 192; k++) begin
      if (k > 1) @(negedge clk); else @(negedge clk);
      got = {outdata, idle_out, busy, txcomfinish};
      exp = exp_at(k, 16, 192);
      n_checks++;
      if (got !== exp) begin
        n_fail++; $display("FAIL b2b_second cyc %0d got %h expected %h", k, got, exp);
      end
    end
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_end_busy got %b expected 0", busy); end
  endtask

  task automatic test_reset_abort;
    int fin;
    logic [22:0] got, exp;
    fin = 0;
    txelecidle = 1; indata = 20'h13579;
    drive_req(1, 0, 0);
    for (int k = 1; k <= 105; k++) begin
      @(negedge clk);
      got = {outdata, idle_out, busy, txcomfinish};
      if (k <= 100)      exp = exp_at(k, 48, 384);
      else if (k == 101) exp = {20'h0, 3'b100};
      else               exp = {20'h13579, 3'b100};
      if (txcomfinish === 1'b1) fin++;
      n_checks++;
      if (got !== exp) begin
        n_fail++; $display("FAIL abort cyc %0d got %h expected %h", k, got, exp);
      end
      if (k == 100) reset = 1;
      if (k == 101) reset = 0;
    end
    n_checks++;
    if (fin !== 0) begin n_fail++; $display("FAIL abort_finish_count got %0d expected 0", fin); end
    drive_req(0, 1, 0);
    fin = 0;
    for (int k = 1; k <= 192; k++) begin
      @(negedge clk);
      got = {outdata, idle_out, busy, txcomfinish};
      exp = exp_at(k, 16, 192);
      if (txcomfinish === 1'b1) fin++;
      n_checks++;
      if (got !== exp) begin
        n_fail++; $display("FAIL abort_wake cyc %0d got %h expected %h", k, got, exp);
      end
    end
    n_checks++;
    if (fin !== 1) begin n_fail++; $display("FAIL abort_wake_finish_count got %0d expected 1", fin); end
  endtask

  initial begin
    reset = 1; txcominit = 0; txcomwake = 0; txcomsas = 0;
    txelecidle = 0; indata = 20'h0;
    test_reset;
    test_passthrough;
    test_sequence("cominit", 1, 0, 0, 48);
    test_sequence("comwake", 0, 1, 0, 16);
    test_sequence("comsas", 0, 0, 1, 144);
    test_sequence("init_wake", 1, 1, 0, 48);
    test_no_elecidle;
    test_back_to_back;
    test_reset_abort;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
